coord_generator: RTL and testbench

COORD_GENERATOR -- requirements
Module: coord_generator

---
 rtl/coord_generator.sv | 98 +++++++++
 tb/tb_coord_generator.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/coord_generator.sv
// Tags each incoming pixel with its (x,y) position in the frame.
// Flags extra pixels after a frame ends and frames restarted early.
module coord_generator #(
  parameter int data_width    = 8,
  parameter int im_width      = 320,
  parameter int im_height     = 240,
  parameter int im_width_bits = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vsync,
  input  logic                     in_valid,
  input  logic [data_width-1:0]    in_data,
  output logic                     out_enable,
  output logic [data_width-1:0]    out_data,
  output logic [im_width_bits-1:0] out_count_x,
  output logic [im_width_bits-1:0] out_count_y,
  output logic                     out_frame_done,
  output logic [1:0]               out_error
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_t;

  localparam logic [im_width_bits-1:0] X_MAX =
    im_width_bits'(im_width - 1);
  localparam logic [im_width_bits-1:0] Y_MAX =
    im_width_bits'(im_height - 1);

  state_t                   state;
  logic [im_width_bits-1:0] x;
  logic [im_width_bits-1:0] y;

  logic                     accept;
  logic                     last_x;
  logic                     last_y;
  logic [im_width_bits-1:0] cx;
  logic [im_width_bits-1:0] cy;

  // A vsync restarts the frame, so a pixel arriving with it is (0,0).
  always_comb begin
    cx     = in_vsync ? '0 : x;
    cy     = in_vsync ? '0 : y;
    accept = in_valid && (in_vsync || state == ACTIVE);
    last_x = (cx == X_MAX);
    last_y = (cy == Y_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      x              <= '0;
      y              <= '0;
      out_enable     <= 1'b0;
      out_data       <= '0;
      out_count_x    <= '0;
      out_count_y    <= '0;
      out_frame_done <= 1'b0;
      out_error      <= 2'b00;
    end else begin
      out_enable     <= 1'b0;
      out_frame_done <= 1'b0;

      if (in_vsync) begin
        if (state == ACTIVE && (x != '0 || y != '0))
          out_error[1] <= 1'b1;
        state <= ACTIVE;
        x     <= '0;
        y     <= '0;
      end else if (state == DONE && in_valid) begin
        out_error[0] <= 1'b1;
      end

      if (accept) begin
        out_enable  <= 1'b1;
        out_data    <= in_data;
        out_count_x <= cx;
        out_count_y <= cy;
        if (!last_x) begin
          x <= cx + 1'b1;
        end else begin
          x <= '0;
          if (!last_y) begin
            y <= cy + 1'b1;
          end else begin
            y              <= '0;
            state          <= DONE;
            out_frame_done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_coord_generator.sv
// Bench for coord_generator: vector table, corner sequences and
// random traffic checked against a frame-index reference model.
module tb_coord_generator;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int XB = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_vsync;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_enable;
  logic [DW-1:0] out_data;
  logic [XB-1:0] out_count_x;
  logic [XB-1:0] out_count_y;
  logic          out_frame_done;
  logic [1:0]    out_error;

  coord_generator #(
    .data_width   (DW),
    .im_width     (W),
    .im_height    (H),
    .im_width_bits(XB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_vsync      (in_vsync),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .out_enable    (out_enable),
    .out_data      (out_data),
    .out_count_x   (out_count_x),
    .out_count_y   (out_count_y),
    .out_frame_done(out_frame_done),
    .out_error     (out_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_seen = 0;

  // Reference: frame position is a single pixel index n.
  // mode 0 = waiting for first vsync, 1 = in frame, 2 = frame complete.
  int            m_mode = 0;
  int            m_n = 0;
  logic          m_en = 1'b0;
  logic          m_fd = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic [XB-1:0] m_x = '0;
  logic [XB-1:0] m_y = '0;
  logic [1:0]    m_err = 2'b00;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model(input logic r, input logic vs, input logic val,
                       input logic [DW-1:0] d);
    m_en = 1'b0;
    m_fd = 1'b0;
    if (r) begin
      m_mode = 0; m_n = 0; m_data = '0;
      m_x = '0; m_y = '0; m_err = 2'b00;
    end else begin
      if (vs) begin
        if (m_mode == 1 && m_n != 0) m_err[1] = 1'b1;
        m_mode = 1;
        m_n = 0;
      end
      if (val) begin
        if (m_mode == 1) begin
          m_en = 1'b1;
          m_data = d;
          m_x = XB'(m_n % W);
          m_y = XB'(m_n / W);
          m_n++;
          if (m_n == W * H) begin
            m_fd = 1'b1;
            m_mode = 2;
            m_n = 0;
          end
        end else if (m_mode == 2) begin
          m_err[0] = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic vs, input logic val,
                      input logic [DW-1:0] d);
    @(negedge clk);
    rst = r; in_vsync = vs; in_valid = val; in_data = d;
    @(posedge clk);
    model(r, vs, val, d);
    #1;
    if (out_frame_done === 1'b1) fd_seen++;
    check("model",
          32'({out_enable, out_data, out_count_x, out_count_y,
               out_frame_done, out_error}),
          32'({m_en, m_data, m_x, m_y, m_fd, m_err}));
  endtask

  task automatic pix(input logic [DW-1:0] d);
    step(1'b0, 1'b0, 1'b1, d);
  endtask

  typedef struct {
    logic          r, vs, val;
    logic [DW-1:0] d;
    logic          en;
    logic [DW-1:0] od;
    logic [XB-1:0] ox, oy;
    logic          fd;
    logic [1:0]    err;
  } vec_t;

  vec_t tbl[$];

  initial begin
    vec_t v;
    rst = 1'b1; in_vsync = 1'b0; in_valid = 1'b0; in_data = '0;

    // Full clean frame, data 0..11.
    v = '{1, 0, 1, 8'h55, 0, 0, 0, 0, 0, 2'b00};
    tbl.push_back(v);
    v = '{0, 0, 1, 8'h66, 0, 0, 0, 0, 0, 2'b00};
    tbl.push_back(v);
    v = '{0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 2'b00};
    tbl.push_back(v);
    for (int i = 0; i < W * H; i++) begin
      v = '{0, 0, 1, DW'(i), 1, DW'(i), XB'(i % W), XB'(i / W),
            (i == W * H - 1), 2'b00};
      tbl.push_back(v);
    end
    v = '{0, 0, 0, 8'h77, 0, 8'd11, 3, 2, 0, 2'b00};
    tbl.push_back(v);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].vs, tbl[i].val, tbl[i].d);
      check($sformatf("vec%0d", i),
            32'({out_enable, out_data, out_count_x, out_count_y,
                 out_frame_done, out_error}),
            32'({tbl[i].en, tbl[i].od, tbl[i].ox, tbl[i].oy,
                 tbl[i].fd, tbl[i].err}));
    end

    // Gapped valids: alternate cycles, outputs hold in gaps.
    step(1'b0, 1'b1, 1'b0, '0);
    fd_seen = 0;
    for (int i = 0; i < W * H; i++) begin
      pix(DW'(i + 16));
      check("gap_xy", 32'({out_count_x, out_count_y}),
            32'({XB'(i % W), XB'(i / W)}));
      step(1'b0, 1'b0, 1'b0, 8'hEE);
      check("gap_hold", 32'({out_enable, out_data, out_count_x}),
            32'({1'b0, DW'(i + 16), XB'(i % W)}));
    end
    check("gap_fd", 32'(fd_seen), 32'd1);
    check("gap_err", 32'(out_error), 32'd0);

    // Overflow: 13th valid after full frame.
    pix(8'h99);
    check("ovf_en", 32'(out_enable), 32'd0);
    check("ovf_err", 32'(out_error), 32'd1);
    step(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < W * H; i++) pix(DW'(i));
    check("ovf_sticky", 32'(out_error), 32'd1);

    // Short frame: vsync after 5 pixels.
    step(1'b1, 1'b0, 1'b0, '0);
    check("rst_err", 32'(out_error), 32'd0);
    step(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) pix(DW'(i));
    step(1'b0, 1'b1, 1'b0, '0);
    check("short_err", 32'(out_error), 32'd2);
    fd_seen = 0;
    for (int i = 0; i < W * H; i++) begin
      pix(DW'(i + 32));
      if (i == 0)
        check("short_restart", 32'({out_count_x, out_count_y}), 32'd0);
    end
    check("short_fd", 32'(fd_seen), 32'd1);
    check("short_err2", 32'(out_error), 32'd2);

    // Simultaneous vsync and valid.
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 8'hAA);
    check("sim_pix", 32'({out_enable, out_data, out_count_x, out_count_y}),
          32'({1'b1, 8'hAA, XB'(0), XB'(0)}));
    pix(8'hBB);
    check("sim_next", 32'({out_count_x, out_count_y}),
          32'({XB'(1), XB'(0)}));

    // Reset after 6 pixels, then a clean frame.
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) pix(DW'(i + 1));
    step(1'b1, 1'b0, 1'b1, 8'h42);
    check("mid_rst", 32'({out_enable, out_data, out_count_x, out_count_y,
                          out_frame_done, out_error}), 32'd0);
    pix(8'h43);
    check("post_rst_ignore", 32'(out_enable), 32'd0);
    step(1'b0, 1'b1, 1'b0, '0);
    fd_seen = 0;
    for (int i = 0; i < W * H; i++) begin
      pix(DW'(4 * (i / W) + i % W));
      check("clean_data", 32'(out_data), 32'(i));
    end
    check("clean_fd", 32'(fd_seen), 32'd1);
    check("clean_err", 32'(out_error), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 24) == 0,
           $urandom_range(0, 9) < 7,
           DW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
